dffram_arbiter: RTL
===================

Name: dffram_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port DFFRAM macro (32-bit data, byte write enables, EN-gated, 1-cycle registered read) between requester 0 (CPU bus bridge) and requester 1 (DMA engine).
- Serialises accesses, registers the RAM command, and routes read data back with a valid strobe to the requester that issued the read.
- Throughput is one access per cycle.

Parameters:
- COLS, 1, number of 256-word RAM columns; address width AW = 8 + clog2(COLS) is derived, not a parameter.

Ports:
- CLK  input  1  clock; all state on rising edge
- RST  input  1  asynchronous, active-high reset
- p0_req  input  1  requester 0 access request; held with fields until p0_gnt
- p0_we  input  4  requester 0 byte write enables; 0000 = read
- p0_addr  input  AW  requester 0 word address
- p0_wdata  input  32  requester 0 write data
- p0_gnt  output  1  requester 0 accepted this cycle (combinational)
- p0_rdata  output  32  requester 0 read data
- p0_rvalid  output  1  p0_rdata valid this cycle
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid: same as p0_*, for requester 1
- ram_en  output  1  RAM EN
- ram_we  output  4  RAM WE
- ram_a  output  AW  RAM A
- ram_di  output  32  RAM Di
- ram_do  input  32  RAM Do

Behaviour:
- Reset (async, RST=1):
  - ram_en=0, ram_we=0, ram_a=0, ram_di=0.
  - p0_rvalid=p1_rvalid=0.
  - Pipeline tag cleared; last_grant pointer=1, so port 0 wins the first contention.
- Grant (cycle T):
  - gnt is combinational from req and last_grant. At most one gnt per cycle.
  - Only one req high: that port is granted.
  - Both req high: the port not equal to last_grant is granted.
  - last_grant updates at the end of T to the granted port.
  - No req: no gnt, last_grant unchanged.
- Command stage:
  - At the edge ending T, ram_en<=1 and ram_we/ram_a/ram_di<=the granted port's fields.
  - With no grant: ram_en<=0, ram_we<=0; ram_a and ram_di hold their values.
  - The RAM samples at the edge ending T+1.
- Response stage:
  - Read (we==0) granted in T: rvalid of that port =1 during T+2. A registered tag (valid, port) tracks the read through two stages.
  - px_rdata = ram_do when that port's rvalid=1, else 0.
  - Writes produce no rvalid; a write is complete on gnt.
- Back-to-back grants every cycle are legal. Responses return in grant order, one per cycle, fixed latency 2.
- Ordering: accesses are serialised in grant order. A read granted after a write to the same address, from either port, returns the written data.
- Partial write (e.g. we=0011) changes only the enabled bytes. No rvalid results.
- Reset mid-operation: in-flight command and tag are discarded; no rvalid after reset deassertion for pre-reset grants.
- A requester dropping req before gnt is legal. No state is affected.

Optional Feature:
- Macro: DFFRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins contention; last_grant is unused and p1 can starve.
- Undefined: round-robin as above.
- Grant latency, ordering and response timing are identical in both builds.

Test Plan:
- Reset, then p0 write addr 0x05 data 0xDEADBEEF we=1111, then p0 read 0x05 -> p0_gnt same cycle as each req; p0_rvalid exactly 2 cycles after the read grant with p0_rdata=0xDEADBEEF; p1_rvalid stays 0.
- p0 and p1 both hold reads for 4 cycles at 0x01/0x02 (preloaded 0x11111111/0x22222222) -> grants alternate p0,p1,p0,p1; rvalids alternate with the matching data, one per cycle.
- Same cycle: p0 writes 0xA5A5A5A5 to 0x10 while p1 reads 0x10; p0 wins -> p1 granted next cycle; p1_rdata=0xA5A5A5A5.
- Word 0x20=0x00000000; p1 write we=0100 data 0x00FF0000; read back -> 0x00FF0000; no rvalid on the write.
- Grant a read, assert RST the following cycle -> no rvalid on either port; after release, ram_en=0 until the next grant and port 0 wins the first contention.
- DFFRAM_ARB_FIXED_PRIO_EN defined, both ports requesting for 3 cycles -> p0_gnt=1 all 3 cycles, p1_gnt=0; p1 is granted the cycle p0_req drops.

Source files
------------

// File: rtl/dffram_arbiter_if.sv
// dffram_arbiter_if: one requester's access/response bundle toward the DFFRAM arbiter.
// master = requester side, slave = arbiter side.
interface dffram_arbiter_if #(parameter int AW = 8);
   logic          req;
   logic [3:0]    we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          gnt;
   logic [31:0]   rdata;
   logic          rvalid;
   modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
   modport slave (input req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/dffram_arbiter.sv
// dffram_arbiter: two-port round-robin arbiter in front of one single-port DFFRAM, fixed read latency 2.
// Define DFFRAM_ARB_FIXED_PRIO_EN to make port 0 always win contention instead of round-robin.
module dffram_arbiter #(
   parameter int  COLS = 1,
   localparam int AW  = 8 + $clog2(COLS)
) (
   input  logic           CLK,
   input  logic           RST,
   dffram_arbiter_if.slave p0,
   dffram_arbiter_if.slave p1,
   output logic           ram_en,
   output logic [3:0]     ram_we,
   output logic [AW-1:0]  ram_a,
   output logic [31:0]    ram_di,
   input  logic [31:0]    ram_do
);
   logic       g0, g1, any;
   logic [3:0] sel_we;
   logic       tag1_v, tag1_p, tag2_v, tag2_p;
`ifdef DFFRAM_ARB_FIXED_PRIO_EN
   assign g0 = p0.req;
`else
   logic last_grant;
   // last_grant=1 means port 1 was served last, so port 0 wins the next contention
   assign g0 = p0.req & (~p1.req | last_grant);
   always_ff @(posedge CLK or posedge RST)
      if (RST) last_grant <= 1'b1;
      else if (p0.req | p1.req) last_grant <= ~g0;
`endif
   assign g1     = p1.req & ~g0;
   assign any    = g0 | g1;
   assign sel_we = g0 ? p0.we : p1.we;
   assign p0.gnt = g0;
   assign p1.gnt = g1;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ram_en <= 1'b0;
         ram_we <= 4'h0;
         ram_a  <= '0;
         ram_di <= '0;
         tag1_v <= 1'b0;
         tag1_p <= 1'b0;
         tag2_v <= 1'b0;
         tag2_p <= 1'b0;
      end else begin
         ram_en <= any;
         ram_we <= any ? sel_we : 4'h0;
         if (any) begin
            ram_a  <= g0 ? p0.addr : p1.addr;
            ram_di <= g0 ? p0.wdata : p1.wdata;
         end
         tag1_v <= any & (sel_we == 4'h0);
         tag1_p <= g1;
         tag2_v <= tag1_v;
         tag2_p <= tag1_p;
      end
   end
   assign p0.rvalid = tag2_v & ~tag2_p;
   assign p1.rvalid = tag2_v & tag2_p;
   assign p0.rdata  = p0.rvalid ? ram_do : 32'h0;
   assign p1.rdata  = p1.rvalid ? ram_do : 32'h0;
endmodule
